// File: rtl/pipeline_flow_ctrl_if.sv
// Pipeline hazard/flow-control bundle between the datapath stages and the sequencer.
// master = datapath side (drives hazard inputs), slave = sequencer (drives enables/flushes).
interface pipeline_flow_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_undef;
    logic             id_kernel;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_br_taken;
    logic             irq;
    logic             mem_busy;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             pipe_en;
    logic [2:0]       pc_src;
    logic             epc_save;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, id_undef, id_kernel,
               ex_memread, ex_rt, ex_br_taken, irq, mem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_en, pc_src, epc_save, bus_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, id_undef, id_kernel,
               ex_memread, ex_rt, ex_br_taken, irq, mem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush,
               pipe_en, pc_src, epc_save, bus_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline; Mealy outputs, zero-cycle decision.
// Memory wait freezes the whole pipe until mem_busy drops or the wait limit forces a bus-error trap.
module pipeline_flow_ctrl #(
    parameter int MAX_MEM_WAIT = 8,
    parameter int CNT_W        = 16
) (
    input  logic                 sysclk,
    input  logic                 reset,
    pipeline_flow_ctrl_if.slave  fc
);
    localparam int            WW         = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_MEM_WAIT);
    localparam logic [2:0]    SRC_PC4    = 3'b000;
    localparam logic [2:0]    SRC_BR     = 3'b001;
    localparam logic [2:0]    SRC_JMP    = 3'b010;
    localparam logic [2:0]    SRC_IRQ    = 3'b100;
    localparam logic [2:0]    SRC_EXC    = 3'b101;

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, TRAP} state_t;

    state_t           state_q, state_d;
    logic             irq_pend_q, irq_pend_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d, wait_inc;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;

    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
    logic             pipe_en, epc_save, bus_err;
    logic [2:0]       pc_src;

    assign load_use = fc.ex_memread && (fc.ex_rt != 5'd0) &&
                      ((fc.ex_rt == fc.id_rs) || (fc.id_uses_rt && (fc.ex_rt == fc.id_rt)));
    // wait_inc counts the busy cycle being evaluated now, so the limit trips on the Nth busy cycle.
    assign wait_inc = wait_cnt_q + WW'(1);

    always_comb begin
        state_d      = state_q;
        irq_pend_d   = irq_pend_q | fc.irq;
        wait_cnt_d   = wait_cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pipe_en      = 1'b1;
        pc_src       = SRC_PC4;
        epc_save     = 1'b0;
        bus_err      = 1'b0;

        if (fc.mem_busy && state_q != MEM_WAIT) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_en     = 1'b0;
            state_d     = MEM_WAIT;
            wait_cnt_d  = WW'(1);
        end else begin
            case (state_q)
                RUN: begin
                    if (fc.id_undef && !fc.id_kernel) begin
                        pc_src      = SRC_EXC;
                        epc_save    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = TRAP;
                    end else if (fc.ex_br_taken) begin
                        pc_src      = SRC_BR;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (irq_pend_q && !fc.id_kernel) begin
                        pc_src      = SRC_IRQ;
                        epc_save    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        irq_pend_d  = 1'b0;
                        state_d     = TRAP;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = LU_STALL;
                    end else if (fc.id_jump) begin
                        pc_src      = SRC_JMP;
                        if_id_flush = 1'b1;
                    end
                end
                LU_STALL: begin
                    state_d = RUN;
                    if (fc.id_jump) begin
                        pc_src      = SRC_JMP;
                        if_id_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!fc.mem_busy) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else if (wait_inc == WAIT_LIMIT) begin
                        bus_err      = 1'b1;
                        pc_src       = SRC_EXC;
                        epc_save     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_d      = TRAP;
                        wait_cnt_d   = '0;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_en     = 1'b0;
                        wait_cnt_d  = wait_inc;
                    end
                end
                TRAP:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end

        // Reset acts on the outputs combinationally so the pipe is held the instant it asserts.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pipe_en      = 1'b0;
            pc_src       = SRC_PC4;
            epc_save     = 1'b0;
            bus_err      = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            irq_pend_q  <= 1'b0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            irq_pend_q  <= irq_pend_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fc.pc_write     = pc_write;
    assign fc.if_id_write  = if_id_write;
    assign fc.if_id_flush  = if_id_flush;
    assign fc.id_ex_flush  = id_ex_flush;
    assign fc.ex_mem_flush = ex_mem_flush;
    assign fc.pipe_en      = pipe_en;
    assign fc.pc_src       = pc_src;
    assign fc.epc_save     = epc_save;
    assign fc.bus_err      = bus_err;
    assign fc.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: expected output vectors are queued as each step is
// driven and popped at the following falling edge; stall_cnt is tracked by a saturating model.
module tb_pipeline_flow_ctrl;
    localparam int CW = 4;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_en, pc_src, epc_save, bus_err}
    localparam logic [10:0] RST = 11'b0_0_1_1_1_0_000_0_0;
    localparam logic [10:0] DEF = 11'b1_1_0_0_0_1_000_0_0;
    localparam logic [10:0] FRZ = 11'b0_0_0_0_0_0_000_0_0;
    localparam logic [10:0] BR  = 11'b1_1_1_1_0_1_001_0_0;
    localparam logic [10:0] EXC = 11'b1_1_1_1_0_1_101_1_0;
    localparam logic [10:0] IRQ = 11'b1_1_1_1_0_1_100_1_0;
    localparam logic [10:0] LU  = 11'b0_0_0_1_0_1_000_0_0;
    localparam logic [10:0] JMP = 11'b1_1_1_0_0_1_010_0_0;
    localparam logic [10:0] TMO = 11'b1_1_1_1_1_1_101_1_1;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysclk = ~sysclk;

    pipeline_flow_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_flow_ctrl #(.MAX_MEM_WAIT(8), .CNT_W(CW)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .fc     (bus.slave)
    );

    logic [10:0] exp_q[$];
    string       tag_q[$];
    int          n_cmp     = 0;
    int          n_err     = 0;
    int          exp_stall = 0;

    task automatic idle();
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.id_uses_rt  = 1'b0;
        bus.id_jump     = 1'b0;
        bus.id_undef    = 1'b0;
        bus.id_kernel   = 1'b0;
        bus.ex_memread  = 1'b0;
        bus.ex_rt       = 5'd0;
        bus.ex_br_taken = 1'b0;
        bus.irq         = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    // Inputs are already driven for this cycle; queue the expectation, then check it mid-cycle.
    task automatic step(input logic [10:0] e_in, input string tag);
        logic [10:0]   got;
        logic [10:0]   e;
        logic [CW-1:0] cnt_exp;
        string         t;
        exp_q.push_back(e_in);
        tag_q.push_back(tag);
        @(negedge sysclk);
        got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush,
               bus.pipe_en, bus.pc_src, bus.epc_save, bus.bus_err};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s outputs: got=%b exp=%b", t, got, e);
        end
        cnt_exp = exp_stall[CW-1:0];
        n_cmp++;
        assert (bus.stall_cnt === cnt_exp) else begin
            n_err++;
            $error("FAIL %s stall_cnt: got=%0d exp=%0d", t, bus.stall_cnt, cnt_exp);
        end
        if (!e[10] && reset && exp_stall < (2**CW - 1)) exp_stall++;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        idle();
        step(RST, "reset_state");
        reset = 1'b1;
        step(DEF, "idle_run");

        // load-use on rs, one bubble then normal
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
        step(LU, "lu_rs");
        bus.ex_memread = 1'b0;
        step(DEF, "lu_rs_release");
        idle();
        step(DEF, "lu_rs_after");

        // rt hazard only when rt is actually read; $zero never hazards
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd9; bus.id_rt = 5'd9; bus.id_rs = 5'd3;
        step(DEF, "lu_rt_unused");
        bus.id_uses_rt = 1'b1;
        step(LU, "lu_rt_used");
        bus.ex_memread = 1'b0;
        step(DEF, "lu_rt_release");
        idle();
        bus.ex_memread = 1'b1;
        step(DEF, "lu_r0");

        // jumps, including a jump resolved in the load-use bubble cycle
        idle();
        bus.id_jump = 1'b1;
        step(JMP, "jump_run");
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8;
        step(LU, "lu_over_jump");
        bus.ex_memread = 1'b0;
        step(JMP, "jump_in_lu_stall");
        idle();
        step(DEF, "jump_after");

        // taken branch defers a pending IRQ by one cycle
        bus.irq = 1'b1;
        step(DEF, "irq_sample");
        bus.irq = 1'b0; bus.ex_br_taken = 1'b1;
        step(BR, "br_over_irq");
        bus.ex_br_taken = 1'b0;
        step(IRQ, "irq_taken");
        step(DEF, "irq_trap_cycle");
        step(DEF, "irq_pend_cleared");

        // kernel-mode instruction masks the IRQ until user code reaches ID
        bus.irq = 1'b1;
        step(DEF, "irq_sample2");
        bus.irq = 1'b0; bus.id_kernel = 1'b1;
        step(DEF, "irq_masked_kernel");
        bus.id_kernel = 1'b0;
        step(IRQ, "irq_after_kernel");
        step(DEF, "irq_trap_cycle2");

        // undefined instruction beats a taken branch; kernel undef is ignored
        bus.id_undef = 1'b1; bus.ex_br_taken = 1'b1;
        step(EXC, "undef_over_br");
        idle();
        step(DEF, "exc_trap_cycle");
        step(DEF, "exc_after");
        bus.id_undef = 1'b1; bus.id_kernel = 1'b1;
        step(DEF, "undef_kernel");
        idle();

        // short memory wait: three frozen cycles, then resume without error
        bus.mem_busy = 1'b1; bus.id_undef = 1'b1;
        step(FRZ, "mem_over_undef");
        bus.id_undef = 1'b0;
        step(FRZ, "mem_wait2");
        step(FRZ, "mem_wait3");
        bus.mem_busy = 1'b0;
        step(DEF, "mem_release");
        step(DEF, "mem_after");

        // memory timeout on the eighth busy cycle
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 7; i++) step(FRZ, "tmo_wait");
        step(TMO, "tmo_trap");
        bus.mem_busy = 1'b0;
        step(DEF, "tmo_trap_cycle");
        step(DEF, "tmo_after");

        // reset asserted mid-wait: outputs and counter clear immediately, state back to RUN
        bus.mem_busy = 1'b1;
        step(FRZ, "pre_reset_wait1");
        step(FRZ, "pre_reset_wait2");
        reset = 1'b0;
        exp_stall = 0;
        step(RST, "reset_mid_wait");
        reset = 1'b1; bus.mem_busy = 1'b0; bus.id_jump = 1'b1;
        step(JMP, "run_after_reset");
        idle();
        step(DEF, "idle_after_reset");

        // stall counter saturation at 2^CW-1
        for (int k = 0; k < 2; k++) begin
            bus.mem_busy = 1'b1;
            for (int i = 0; i < 7; i++) step(FRZ, "sat_wait");
            step(TMO, "sat_tmo");
            bus.mem_busy = 1'b0;
            step(DEF, "sat_trap_cycle");
        end
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step(FRZ, "sat_freeze");
        bus.mem_busy = 1'b0;
        step(DEF, "sat_release");
        step(DEF, "sat_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
